prio_encoder_seq: RTL and testbench
===================================

Name: prio_encoder_seq

Overview:
- Parametrised, registered successor to the plain 8-3 encoder.
- Latches an N-bit request vector and emits the index of every set bit, one per handshake.
- Highest index is emitted first; each accepted index is cleared from the pending register.
- Used wherever several requests must be serialised into binary codes, such as interrupt or key scanning.

Parameters:
- N, 8, request vector width (N ≥ 2).
- W, $clog2(N), output code width; derived, not overridden.

Ports:
- iClk  input  1  system clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iLoad  input  1  capture iData into the pending register; honoured only in IDLE.
- iData  input  N  request vector; bit k means request k.
- iReady  input  1  consumer accepts the current oData when oValid=1.
- oData  output  W  index of the highest set pending bit; 0 when oValid=0.
- oValid  output  1  oData is valid.
- oBusy  output  1  FSM is in SCAN.
- oDone  output  1  one-cycle pulse after the last pending bit is accepted.
- oNone  output  1  one-cycle pulse when an all-zero vector was loaded.

Behaviour:
- Reset (iRst=1 at a clock edge):
  - pend=0, state=IDLE.
  - oData=0, oValid=0, oBusy=0, oDone=0, oNone=0.
  - Reset has priority over every other input, including mid-SCAN; the partial vector is discarded and no oDone is generated.
- FSM states: IDLE, SCAN.
- IDLE:
  - iLoad=1 with iData≠0: pend←iData, next state SCAN.
  - iLoad=1 with iData=0: stay IDLE, oNone=1 on the next cycle only.
  - iLoad=0: hold.
- SCAN:
  - oValid=1, oBusy=1.
  - oData = index of the MSB set in pend, from the combinational sub-module.
  - Latency from the iLoad edge to first oValid: 1 cycle.
- Handshake:
  - A transfer occurs on an edge where oValid=1 and iReady=1; pend[oData]←0 on that edge.
  - With iReady=0, oData and oValid hold stable indefinitely.
  - Back-to-back transfers are allowed: one index per cycle at full rate.
- Last bit:
  - When a transfer clears the final set bit, the next state is IDLE.
  - oValid drops and oDone=1 for exactly 1 cycle.
- iLoad during SCAN is ignored, including on the cycle of the last transfer; no queueing.
- iData is sampled only at the load edge; later changes have no effect on the current scan.
- oDone and oNone are never both 1.
- A full vector (all N bits set) yields N transfers, in order N-1 down to 0.

Optional Feature:
- Macro: PRIO_ENC_POPCNT_EN.
- When defined:
  - Extra output port oCount [W:0] gives the number of set bits in pend.
  - Reset value 0.
  - Updated on load (popcount of iData) and decremented by 1 on each transfer.
- When undefined:
  - The port and its counter logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package prio_enc_pkg:
  - state typedef (IDLE, SCAN);
  - function computing W from N.
- One sub-module, prio_enc_comb, parametrised by N:
  - purely combinational;
  - input vec[N-1:0], outputs idx[W-1:0] (MSB-first) and any (OR-reduce);
  - idx=0 when any=0.
- The top level holds the FSM, the pend register, the handshake and the optional counter.

Test Plan:
- Reset, then iLoad=1 with iData=8'b1000_0001 and iReady=1 held → oData=7 then 0 on consecutive cycles, then oDone pulse, oBusy=0.
- iData=8'b0010_0100 with iReady=0 for 5 cycles, then 1 → oData stays 5 with oValid=1 throughout the stall, then 2, then oDone.
- iLoad with iData=0 → oNone=1 for one cycle; oValid never rises; state remains IDLE.
- iData=8'hFF with iReady=1 → oData sequence 7,6,5,4,3,2,1,0 in 8 cycles. With PRIO_ENC_POPCNT_EN: oCount 8→0.
- Load 8'b0000_1110, accept one index (3), assert iRst → next cycle all outputs 0. A fresh load of 8'b0000_0001 then yields oData=0 and oDone.
- During SCAN of 8'b0000_0011, pulse iLoad with 8'hF0 → ignored; only 1,0 are emitted; after oDone the next iLoad is honoured.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Output code width for an N-bit request vector.
  function automatic int unsigned calcW(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational MSB-first priority encoder; idx is 0 when no bit is set.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = calcW(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan so the highest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/prio_encoder_seq.sv
// Registered priority encoder: loads a request vector and hands out set-bit
// indices highest first, one per valid/ready transfer.
// Optional: define PRIO_ENC_POPCNT_EN to add the oCount pending-bit counter.
module prio_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = calcW(N)
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iLoad,
  input  logic [N-1:0] iData,
  input  logic         iReady,
  output logic [W-1:0] oData,
  output logic         oValid,
  output logic         oBusy,
  output logic         oDone,
  output logic         oNone
`ifdef PRIO_ENC_POPCNT_EN
  ,
  output logic [W:0]   oCount
`endif
);

  state_t       state, stateNext;
  logic [N-1:0] pend, pendNext;
  logic         doneNext, noneNext;
  logic [W-1:0] idx;
  logic         any;
  logic         xfer;

  prio_enc_comb #(.N(N)) uEnc (
    .vec (pend),
    .idx (idx),
    .any (any)
  );

  assign xfer = (state == SCAN) && iReady;

  always_comb begin
    stateNext = state;
    pendNext  = pend;
    doneNext  = 1'b0;
    noneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (iLoad) begin
          if (|iData) begin
            pendNext  = iData;
            stateNext = SCAN;
          end else begin
            noneNext = 1'b1;
          end
        end
      end
      SCAN: begin
        if (iReady) begin
          pendNext[idx] = 1'b0;
          if (pendNext == '0) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      pend  <= '0;
      oDone <= 1'b0;
      oNone <= 1'b0;
    end else begin
      state <= stateNext;
      pend  <= pendNext;
      oDone <= doneNext;
      oNone <= noneNext;
    end
  end

  assign oValid = (state == SCAN) && any;
  assign oBusy  = (state == SCAN);
  assign oData  = oValid ? idx : '0;

`ifdef PRIO_ENC_POPCNT_EN
  logic [W:0] loadCount;

  always_comb begin
    loadCount = '0;
    for (int unsigned i = 0; i < N; i++) begin
      loadCount = loadCount + {{W{1'b0}}, iData[i]};
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCount <= '0;
    end else if (state == IDLE) begin
      if (iLoad) oCount <= loadCount;
    end else if (xfer) begin
      oCount <= oCount - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Directed bench for prio_encoder_seq: a per-cycle vector table plus
// hand-written stall and mid-scan reset sequences.
module tb_prio_encoder_seq;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         iClk = 1'b0;
  logic         iRst = 1'b1;
  logic         iLoad = 1'b0;
  logic [N-1:0] iData = '0;
  logic         iReady = 1'b0;
  logic [W-1:0] oData;
  logic         oValid, oBusy, oDone, oNone;
`ifdef PRIO_ENC_POPCNT_EN
  logic [W:0]   oCount;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         rst;
    logic         load;
    logic [N-1:0] data;
    logic         ready;
    logic [W-1:0] expData;
    logic         expValid;
    logic         expBusy;
    logic         expDone;
    logic         expNone;
    logic [W:0]   expCount;
  } vec_t;

  vec_t vecs[$];

  prio_encoder_seq #(.N(N)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iLoad  (iLoad),
    .iData  (iData),
    .iReady (iReady),
    .oData  (oData),
    .oValid (oValid),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oNone  (oNone)
`ifdef PRIO_ENC_POPCNT_EN
    ,
    .oCount (oCount)
`endif
  );

  always #5 iClk = ~iClk;

  function automatic void add(input logic rst, input logic load, input logic [N-1:0] data,
                              input logic ready, input logic [W-1:0] d, input logic v,
                              input logic b, input logic dn, input logic nn,
                              input logic [W:0] c);
    vec_t r;
    r.rst = rst; r.load = load; r.data = data; r.ready = ready;
    r.expData = d; r.expValid = v; r.expBusy = b; r.expDone = dn; r.expNone = nn;
    r.expCount = c;
    vecs.push_back(r);
  endfunction

  // Apply inputs, clock once, then settle 1 time unit past the edge.
  task automatic step(input logic rst, input logic load, input logic [N-1:0] data,
                      input logic ready);
    iRst = rst; iLoad = load; iData = data; iReady = ready;
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] d, input logic v,
                       input logic b, input logic dn, input logic nn, input logic [W:0] c);
    tests++;
    if ({oData, oValid, oBusy, oDone, oNone} !== {d, v, b, dn, nn}) begin
      fails++;
      $display("FAIL %s: got data=%0d valid=%b busy=%b done=%b none=%b, expected data=%0d valid=%b busy=%b done=%b none=%b",
               name, oData, oValid, oBusy, oDone, oNone, d, v, b, dn, nn);
    end
    tests++;
    if (oDone && oNone) begin
      fails++;
      $display("FAIL %s_excl: got done=%b none=%b, expected not both 1", name, oDone, oNone);
    end
`ifdef PRIO_ENC_POPCNT_EN
    tests++;
    if (oCount !== c) begin
      fails++;
      $display("FAIL %s_count: got %0d, expected %0d", name, oCount, c);
    end
`else
    if (c > '1) $display("unexpected count width");
`endif
  endtask

  initial begin
    // Reset, then 0x81 at full rate.
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h81, 1, 7, 1, 1, 0, 0, 2);
    add(0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // All-zero load.
    add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // Full vector: 7 down to 0 then done.
    add(0, 1, 8'hFF, 1, 7, 1, 1, 0, 0, 8);
    for (int k = 6; k >= 0; k--) add(0, 0, 8'h00, 1, W'(k), 1, 1, 0, 0, (W+1)'(k + 1));
    add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    // Load during SCAN is ignored, even on the last transfer; honoured after.
    add(0, 1, 8'h03, 0, 1, 1, 1, 0, 0, 2);
    add(0, 1, 8'hF0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 1, 8'hF0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 8'hF0, 0, 7, 1, 1, 0, 0, 4);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].data, vecs[i].ready);
      check($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expValid, vecs[i].expBusy,
            vecs[i].expDone, vecs[i].expNone, vecs[i].expCount);
    end

    // Stall: 0x24 held for 5 cycles with iReady low, and iData changed meanwhile.
    step(0, 1, 8'h24, 0);
    check("stall_load", 5, 1, 1, 0, 0, 2);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 8'hFF, 0);
      check($sformatf("stall_hold%0d", k), 5, 1, 1, 0, 0, 2);
    end
    step(0, 0, 8'h00, 1);
    check("stall_next", 2, 1, 1, 0, 0, 1);
    step(0, 0, 8'h00, 1);
    check("stall_done", 0, 0, 0, 1, 0, 0);
    step(0, 0, 8'h00, 0);
    check("stall_idle", 0, 0, 0, 0, 0, 0);

    // Reset mid-scan discards the vector with no done pulse.
    step(0, 1, 8'h0E, 1);
    check("rst_load", 3, 1, 1, 0, 0, 3);
    step(0, 0, 8'h00, 1);
    check("rst_xfer3", 2, 1, 1, 0, 0, 2);
    step(1, 0, 8'h00, 1);
    check("rst_mid", 0, 0, 0, 0, 0, 0);
    step(0, 0, 8'h00, 1);
    check("rst_after", 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h01, 0);
    check("rst_reload", 0, 1, 1, 0, 0, 1);
    step(0, 0, 8'h00, 1);
    check("rst_reload_done", 0, 0, 0, 1, 0, 0);
    step(0, 0, 8'h00, 0);
    check("rst_final_idle", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
